muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with HI/LO result registers, for the multi-cycle-capable CPU datapath.
- Executes MULT/MULTU/DIV/DIVU with MIPS semantics using a start/busy/done handshake; the datapath stalls on busy.
- Also supports direct HI/LO writes (MTHI/MTLO); HI/LO are always readable.
- Generalises the fixed 32-bit datapath arithmetic to any even WIDTH.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_sign_fix.sv | 39 +++
 rtl/muldiv_unit.sv | 214 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
//   op_t          : operation encoding presented on the op port.
//   state_t       : sequencer states (IDLE, RUN, FIX, DONE).
//   OP_SIGNED_BIT : op bit that selects signed (MULT/DIV) operation.
//   OP_DIV_BIT    : op bit that selects divide rather than multiply.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam int OP_SIGNED_BIT = 0;
  localparam int OP_DIV_BIT    = 1;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction for the multiply/divide unit. The iterative core works
// on magnitudes only; this block restores two's complement results.
// Ports:
//   is_div : 1 = raw holds {remainder, quotient}, 0 = raw holds the product
//   neg_a  : first operand was negative (always 0 for unsigned ops)
//   neg_b  : second operand was negative (always 0 for unsigned ops)
//   raw    : unsigned result from the iteration, 2*WIDTH bits
//   hi, lo : corrected HI/LO values
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic               neg_a,
  input  logic               neg_b,
  input  logic [2*WIDTH-1:0] raw,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic               neg_res;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Product and quotient are negative when exactly one operand was negative;
  // the remainder follows the sign of the dividend.
  assign neg_res  = neg_a ^ neg_b;
  assign rem      = raw[2*WIDTH-1:WIDTH];
  assign quo      = raw[WIDTH-1:0];
  assign prod_fix = neg_res ? -raw : raw;
  assign quo_fix  = neg_res ? -quo : quo;
  assign rem_fix  = neg_a   ? -rem : rem;

  assign hi = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign lo = is_div ? quo_fix : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers (MIPS semantics).
// One result bit per RUN cycle (radix-2 shift-add multiply, restoring divide)
// on operand magnitudes, followed by one FIX cycle for sign correction.
// Optional build macro:
//   MULDIV_EARLY_OUT_EN : multiplies leave RUN as soon as the remaining
//                         multiplier bits are zero; FIX realigns the product.
// Parameters:
//   WIDTH : operand width, even and >= 4.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start, op, a, b   : launch request, sampled only in IDLE or DONE
//   hilo_we, hilo_sel : direct write of LO (sel=0) or HI (sel=1), not while busy
//   wdata             : direct write data
//   busy              : high in RUN and FIX
//   done              : one-cycle completion pulse, HI/LO valid in that cycle
//   div_zero          : high with done when a divide had b == 0
//   hi, lo            : result registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  op_t              op_in;
  logic [WIDTH-1:0] acc;     // product high half / running remainder
  logic [WIDTH-1:0] low;     // multiplier then product low half / dividend then quotient
  logic [WIDTH-1:0] opnd;    // multiplicand or divisor magnitude
  logic [CNT_W-1:0] cnt;     // iterations completed
  logic             is_div;
  logic             neg_a;
  logic             neg_b;

  // Operand capture at launch.
  logic             accept;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_by_zero;

  assign op_in       = op_t'(op);
  assign accept      = start && (state == IDLE || state == DONE);
  assign sgn         = op_in[OP_SIGNED_BIT];
  assign a_neg       = sgn && a[WIDTH-1];
  assign b_neg       = sgn && b[WIDTH-1];
  assign a_mag       = a_neg ? -a : a;
  assign b_mag       = b_neg ? -b : b;
  assign div_by_zero = op_in[OP_DIV_BIT] && (b == '0);

  // One iteration step for each operation.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] low_step;
  logic             last;

  assign mul_sum   = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc, low[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  // The remainder always stays below the divisor, so the top bit of the
  // difference is a clean borrow flag.
  assign div_ok    = !div_diff[WIDTH];

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (default first) so no latch is inferred.
  always_comb begin
    acc_step = acc;
    low_step = low;
    if (is_div) begin
      acc_step = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      low_step = {low[WIDTH-2:0], div_ok};
    end else begin
      {acc_step, low_step} = {mul_sum, low[WIDTH-1:1]};
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [WIDTH-1:0] ONES = '1;

  // Before step k the low WIDTH-k bits of low are the unconsumed multiplier;
  // after this step only the bits above bit 0 of that field remain.
  always_comb begin
    last = (cnt == CNT_W'(WIDTH - 1));
    if (!is_div && (((low >> 1) & (ONES >> (cnt + 1'b1))) == '0)) begin
      last = 1'b1;
    end
  end
`else
  always_comb begin
    last = (cnt == CNT_W'(WIDTH - 1));
  end
`endif

  // After k steps {acc, low} holds the partial product shifted left by
  // WIDTH-k; divides and full-length multiplies always have k == WIDTH.
  logic [2*WIDTH-1:0] raw;
`ifdef MULDIV_EARLY_OUT_EN
  assign raw = {acc, low} >> (CNT_W'(WIDTH) - cnt);
`else
  assign raw = {acc, low};
`endif

  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  muldiv_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .is_div (is_div),
    .neg_a  (neg_a),
    .neg_b  (neg_b),
    .raw    (raw),
    .hi     (fix_hi),
    .lo     (fix_lo)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the datapath registers are reset along with the control state;
  // they are few and a clean post-reset state keeps HI/LO deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      low      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;

      // Direct writes are blocked in RUN/FIX; a result written later in this
      // block on the same edge takes priority.
      if (hilo_we && state != RUN && state != FIX) begin
        if (hilo_sel) hi <= wdata;
        else          lo <= wdata;
      end

      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (accept) begin
            if (div_by_zero) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
              hi       <= a;
              lo       <= '1;
            end else begin
              state  <= RUN;
              busy   <= 1'b1;
              is_div <= op_in[OP_DIV_BIT];
              neg_a  <= a_neg;
              neg_b  <= b_neg;
              acc    <= '0;
              cnt    <= '0;
              // Shift-add consumes the multiplier from low; restoring divide
              // consumes the dividend from low.
              low    <= op_in[OP_DIV_BIT] ? a_mag : b_mag;
              opnd   <= op_in[OP_DIV_BIT] ? b_mag : a_mag;
            end
          end
        end
        RUN: begin
          acc <= acc_step;
          low <= low_step;
          cnt <= cnt + 1'b1;
          if (last) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          hi    <= fix_hi;
          lo    <= fix_lo;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32). Expected results come from
// a plain-arithmetic reference model and are queued at issue; a monitor pops
// and compares on every done pulse, including the issue-to-done latency.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hilo_we;
  logic         hilo_sel;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_unit #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hilo_we  (hilo_we),
    .hilo_sel (hilo_sel),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           t0;
  } exp_t;

  exp_t         sb[$];
  exp_t         pend;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: MIPS HI/LO semantics from ordinary 64-bit arithmetic.
  function automatic exp_t model(input op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    longint       sx;
    longint       sy;
    logic [63:0]  p;
    logic [W-1:0] ym;
    int           k;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    e.dz  = 1'b0;
    e.t0  = 0;
    e.lat = W + 2;
    e.hi  = '0;
    e.lo  = '0;
    ym    = y;
    k     = 1;
    case (o)
      MULTU: begin
        p = {32'b0, x} * {32'b0, y};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      MULT: begin
        p = sx * sy;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      DIVU: begin
        if (y != 0) begin
          e.lo = x / y;
          e.hi = x % y;
        end
      end
      default: begin
        if (y != 0) begin
          p = sx / sy;
          e.lo = p[31:0];
          p = sx % sy;
          e.hi = p[31:0];
        end
      end
    endcase
    if ((o == DIVU || o == DIV) && y == 0) begin
      e.dz  = 1'b1;
      e.lo  = '1;
      e.hi  = x;
      e.lat = 1;
    end
`ifdef MULDIV_EARLY_OUT_EN
    if (o == MULTU || o == MULT) begin
      if (o == MULT && y[W-1]) ym = -y;
      for (int i = 0; i < W; i++) if (ym[i]) k = i + 1;
      e.lat = k + 2;
    end
`endif
    return e;
  endfunction

  // Called away from the clock edge; returns just after the accepting edge.
  task automatic issue(input op_t o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start   = 1'b0;
    hilo_we = 1'b0;
    e       = model(o, x, y);
    e.t0    = cyc;
    if (push) sb.push_back(e);
    pend = e;
  endtask

  // Returns at the falling edge where done is seen, counting busy cycles.
  task automatic wait_done(output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      if (busy) busy_cycles++;
      n++;
    end while (!done && n < 200);
    check("done_seen", {63'b0, done}, 64'd1);
    model_hi = pend.hi;
    model_lo = pend.lo;
  endtask

  task automatic run_op(input op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    int bc;
    issue(o, x, y, 1'b1);
    wait_done(bc);
  endtask

  task automatic hilo_write(input logic sel, input logic [W-1:0] d);
    hilo_we  = 1'b1;
    hilo_sel = sel;
    wdata    = d;
    @(posedge clk);
    #1;
    hilo_we = 1'b0;
    if (sel) model_hi = d;
    else     model_lo = d;
    check("hilo_write_hi", hi, model_hi);
    check("hilo_write_lo", lo, model_lo);
  endtask

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done pulse with no operation outstanding (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_hi", hi, e.hi);
        check("result_lo", lo, e.lo);
        check("result_div_zero", {63'b0, div_zero}, {63'b0, e.dz});
        check("latency", 64'(cyc - e.t0 + 1), 64'(e.lat));
      end
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [W-1:0] HOLD_A = 32'd1;
  localparam logic [W-1:0] HOLD_B = 32'h8000_0000;
`else
  localparam logic [W-1:0] HOLD_A = 32'd6;
  localparam logic [W-1:0] HOLD_B = 32'd7;
`endif

  initial begin
    int bc;
    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    a        = '0;
    b        = '0;
    hilo_we  = 1'b0;
    hilo_sel = 1'b0;
    wdata    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_div_zero", {63'b0, div_zero}, 64'd0);
    check("reset_hi", hi, 64'd0);
    check("reset_lo", lo, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full-width unsigned multiply: latency and busy length.
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(bc);
    check("multu_max_busy_cycles", 64'(bc), 64'(W + 1));
    check("multu_max_hi_model", {32'b0, model_hi}, 64'hFFFF_FFFE);
    check("multu_max_lo_model", {32'b0, model_lo}, 64'h0000_0001);
    repeat (3) @(negedge clk);
    check("hold_hi", hi, model_hi);
    check("hold_lo", lo, model_lo);

    // Signed multiply, then signed divide.
    run_op(MULT, -32'sd3, 32'd7);
    run_op(DIV, -32'sd7, 32'd2);
    // Divide by zero, most-negative / -1.
    run_op(DIVU, 32'd100, 32'd0);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_lo_model", {32'b0, model_lo}, 64'h8000_0000);
    run_op(DIV, -32'sd5, 32'd0);

    // Start and hilo_we while busy are ignored; then back-to-back issue.
    issue(MULTU, HOLD_A, HOLD_B, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = DIVU;
    a     = 32'd5;
    b     = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    hilo_we  = 1'b1;
    hilo_sel = 1'b0;
    wdata    = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    hilo_we = 1'b0;
    check("busy_ignore_we_hi", hi, model_hi);
    check("busy_ignore_we_lo", lo, model_lo);
    wait_done(bc);
    issue(MULT, 32'h1234_5678, 32'h8765_4321, 1'b1);
    wait_done(bc);

    // Asynchronous reset in the middle of a divide.
    issue(DIV, 32'h7654_3210, 32'd3, 1'b0);
    repeat (11) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_busy", {63'b0, busy}, 64'd0);
    check("midreset_done", {63'b0, done}, 64'd0);
    check("midreset_hi", hi, 64'd0);
    check("midreset_lo", lo, 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(DIVU, 32'd9, 32'd4);

    // Direct writes while idle.
    repeat (2) @(negedge clk);
    hilo_write(1'b1, 32'h0000_1234);
    hilo_write(1'b0, 32'h0000_5678);

    // Direct write in the same cycle as an accepted start.
    hilo_we  = 1'b1;
    hilo_sel = 1'b1;
    wdata    = 32'hCAFE_F00D;
    issue(DIVU, 32'd1000, 32'd7, 1'b1);
    check("we_with_start_hi", hi, 64'hCAFE_F00D);
    wait_done(bc);

    // Short multiplier (early-exit candidate).
    run_op(MULTU, 32'd5, 32'd3);
    run_op(MULT, 32'hFFFF_FFFF, 32'd0);

    // Randomised operations, mixing back-to-back issue with idle gaps.
    for (int n = 0; n < 120; n++) begin
      op_t          o;
      logic [W-1:0] x;
      logic [W-1:0] y;
      o = op_t'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: begin x = 32'h8000_0000; y = '1; end
        2: y = $urandom_range(0, 15);
        3: x = $urandom_range(0, 255);
        default: ;
      endcase
      run_op(o, x, y);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check("idle_hold_hi", hi, model_hi);
        check("idle_hold_lo", lo, model_lo);
        hilo_write(1'($urandom_range(0, 1)), $urandom);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
